// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared FSM state type and default widths for the 1:2 stream demux.
package stream_demux_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;
  localparam int DW_DEFAULT = 8;
  localparam int CW_DEFAULT = 8;
endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: one-entry valid/ready register slice; full throughput when the consumer is ready.
module stream_reg_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = (in_valid && in_ready) || (valid_q && !out_ready);
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/stream_demux1to2.sv
// stream_demux1to2: packet-granular 1:2 stream demux with per-output register slice and packet counter.
module stream_demux1to2
  import stream_demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_last,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_last,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1
);
  state_t        state_q, state_d;
  logic          dest, accept, s0_ready, s1_ready;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  // Destination is only sampled from in_sel while no packet is in flight.
  always_comb begin
    dest     = (state_q == ROUTE1) || (state_q == IDLE && in_sel);
    in_ready = dest ? s1_ready : s0_ready;
    accept   = in_valid && in_ready;
    state_d  = !accept ? state_q : in_last ? IDLE : dest ? ROUTE1 : ROUTE0;
    cnt0_d   = cnt0_q + CW'(out0_valid && out0_ready && out0_last);
    cnt1_d   = cnt1_q + CW'(out1_valid && out1_ready && out1_last);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
  stream_reg_slice #(.W(DW + 1)) u_slice0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !dest),
    .in_ready  (s0_ready),
    .in_data   ({in_last, in_data}),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  ({out0_last, out0_data})
  );
  stream_reg_slice #(.W(DW + 1)) u_slice1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && dest),
    .in_ready  (s1_ready),
    .in_data   ({in_last, in_data}),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  ({out1_last, out1_data})
  );
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
endmodule

// File: doc/stream_demux1to2.md
# stream_demux1to2

Registered 1-to-2 stream demultiplexer: routes packets arriving on one valid/ready input stream to one of two output streams, chosen by a select bit sampled on the first beat of each packet and held until that packet's last beat is accepted. It is the distribution counterpart to the 2:1 multiplexer and sits where a single producer must feed two consumers, with independent back-pressure per output. Each output carries a one-entry register slice and a packet counter.

## Interface
Parameters:
- `DW`, default 8: data width in bits.
- `CW`, default 8: width of each per-output packet counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  DW  input payload.
- `in_last`  in  1  final beat of packet.
- `in_sel`  in  1  destination (0 → out0, 1 → out1); sampled only on a packet's first beat.
- `out0_valid`, `out1_valid`  out  1  output beat valid.
- `out0_ready`, `out1_ready`  in  1  consumer ready.
- `out0_data`, `out1_data`  out  DW  output payload.
- `out0_last`, `out1_last`  out  1  final beat of packet.
- `pkt_cnt0`, `pkt_cnt1`  out  CW  count of packets fully delivered on each output (last beat accepted downstream); wraps modulo 2^CW.

## Operation
- FSM states: IDLE (no packet in progress), ROUTE0, ROUTE1.
- IDLE: destination is `in_sel`. On acceptance with `in_last=0`, go to ROUTE0/ROUTE1 per `in_sel`. On acceptance with `in_last=1` (single-beat packet), stay in IDLE.
- ROUTEn: `in_sel` is ignored and every beat goes to output n. Acceptance with `in_last=1` returns to IDLE.
- `in_ready` = the destination slice can take a beat: it is empty, or its output handshake (`outN_valid && outN_ready`) completes this cycle. `in_ready` never depends on the non-destination output.
- Slice: a one-entry register holding {data, last}. It loads on input acceptance and clears valid on an output handshake with no simultaneous load.
- Packet counter n increments by 1 on each cycle where `outN_valid && outN_ready && outN_last`. It wraps from 2^CW−1 to 0.
- Data and last are never altered. Beat order within each output is preserved.
- No beat is ever dropped or duplicated.

## Timing
- Reset (async assert, sync deassert expected upstream) values:
  - state = IDLE;
  - `out0_valid` = `out1_valid` = 0;
  - `out*_data` = 0, `out*_last` = 0;
  - `pkt_cnt*` = 0;
  - `in_ready` reflects empty slices, i.e. 1.
- Latency: a beat accepted on edge k appears as `outN_valid=1` after edge k.
- Throughput: one beat per cycle per output when the consumer holds ready high. Simultaneous drain and load of the same slice is legal and keeps `outN_valid=1`.
- Packet switch: a new packet to output m may be accepted while output n≠m still holds a stalled beat.
- Back-to-back packets: the cycle after the last beat is accepted, the FSM is in IDLE and samples `in_sel` of the next beat.
- `outN_valid` stays asserted and data stays stable until the handshake completes. There is no combinational path from `in_valid` to `outN_valid`.
- Reset mid-packet: buffered beats are discarded, the FSM returns to IDLE, and counters clear. The next accepted beat is treated as a first beat.

## Structure
- Shared package `stream_demux_pkg`: FSM state enum (IDLE, ROUTE0, ROUTE1) and the default values of `DW` and `CW`.
- Sub-module `stream_reg_slice` (DW+1 bits wide, valid/ready, async active-low reset), instantiated once per output. The top level holds the FSM, the ready steering and the counters.

## Test plan
- Reset, then one packet of 3 beats: data 0x11, 0x22, 0x33 with `in_sel=0` on the first beat, both readies high.
  - out0 shows 0x11, 0x22, 0x33 one cycle after each accept, with last on 0x33.
  - out1 never valid; `pkt_cnt0`=1, `pkt_cnt1`=0.
- Mid-packet select change: packet to out1, and `in_sel` toggles to 0 on beats 2–3.
  - All beats appear on out1; out0 stays idle.
- Back-pressure: hold `out0_ready=0` with a beat 0xA5 buffered.
  - `in_ready`=0 for out0 traffic; 0xA5 is held stable.
  - A single-beat packet 0x5A to out1 is accepted and delivered.
  - Release out0: 0xA5 is delivered; both counters = 1.
- Full-rate streaming: 8-beat packets alternating destinations, readies high.
  - Every beat is delivered in order with no bubbles at the input.
  - After 4 packets: `pkt_cnt0`=2, `pkt_cnt1`=2.
- Wrap and reset: with CW=2, deliver 5 single-beat packets to out0.
  - `pkt_cnt0` sequence is 1, 2, 3, 0, 1.
  - Assert `rst_n` low mid-packet: outputs go invalid immediately, counters read 0.
  - After release, the first beat with `in_sel=1` routes to out1.
